// File: rtl/multi_dataflow_job_arbiter_if.sv
// Job-arbiter bundle: requester handshake, engine start/done/busy, watchdog limit and per-owner events.
// The arbiter connects through the slave modport; the trigger logic and engine FSM use the master modport.
interface multi_dataflow_job_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT_W = 16
);
    localparam int ID_W = $clog2(N_REQ);

    logic                 clear_i;
    logic [N_REQ-1:0]     req_i;
    logic [N_REQ-1:0]     gnt_o;
    logic [ID_W-1:0]      owner_o;
    logic                 owner_valid_o;
    logic                 job_start_o;
    logic                 job_busy_i;
    logic                 job_done_i;
    logic                 abort_o;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic [N_REQ-1:0]     evt_done_o;
    logic [N_REQ-1:0]     evt_err_o;
    logic                 busy_o;
    logic [15:0]          jobs_cnt_o;

    modport slave (
        input  clear_i, req_i, job_busy_i, job_done_i, timeout_i,
        output gnt_o, owner_o, owner_valid_o, job_start_o, abort_o,
               evt_done_o, evt_err_o, busy_o, jobs_cnt_o
    );

    modport master (
        output clear_i, req_i, job_busy_i, job_done_i, timeout_i,
        input  gnt_o, owner_o, owner_valid_o, job_start_o, abort_o,
               evt_done_o, evt_err_o, busy_o, jobs_cnt_o
    );
endinterface

// File: rtl/multi_dataflow_job_arbiter.sv
// Round-robin arbiter that shares one dataflow engine among N_REQ requesters,
// sequencing grant/start/run and guarding every job with a cycle watchdog.
module multi_dataflow_job_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT_W = 16
) (
    input logic                         clk_i,
    input logic                         rst_i,
    multi_dataflow_job_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;

    logic [2:0]           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      owner;
    logic [ID_W-1:0]      owner_next;
    logic [ID_W-1:0]      winner;
    logic [ID_W:0]        cand;
    logic                 any_req;
    logic                 owner_valid;
    logic                 abort_entry;
    logic                 expired;
    logic [TIMEOUT_W-1:0] wdog;
    logic [15:0]          jobs_cnt;
    logic [N_REQ-1:0]     owner_bit;

    // Scan from the farthest offset back toward rr_ptr so the nearest set bit wins.
    always_comb begin
        winner  = rr_ptr;
        any_req = 1'b0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(N_REQ)) begin
                cand = cand - (ID_W + 1)'(N_REQ);
            end
            if (bus.req_i[cand[ID_W-1:0]]) begin
                winner  = cand[ID_W-1:0];
                any_req = 1'b1;
            end
        end
    end

    assign owner_next = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + ID_W'(1);
    assign owner_bit  = N_REQ'(1) << owner;

    // Equality (not >=) means a limit lowered below the running count never fires.
    assign expired = (bus.timeout_i != '0) && (wdog == bus.timeout_i - TIMEOUT_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            abort_entry <= 1'b0;
            wdog        <= '0;
            jobs_cnt    <= '0;
        end else if (bus.clear_i) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            abort_entry <= 1'b0;
            wdog        <= '0;
            jobs_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner       <= winner;
                        owner_valid <= 1'b1;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    state <= S_START;
                end
                S_START: begin
                    wdog  <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (wdog != '1) begin
                        wdog <= wdog + TIMEOUT_W'(1);
                    end
                    if (bus.job_done_i) begin
                        state <= S_DONE;
                    end else if (expired) begin
                        abort_entry <= 1'b1;
                        state       <= S_ABORT;
                    end
                end
                S_DONE: begin
                    if (jobs_cnt != 16'hFFFF) begin
                        jobs_cnt <= jobs_cnt + 16'd1;
                    end
                    rr_ptr      <= owner_next;
                    owner_valid <= 1'b0;
                    state       <= S_IDLE;
                end
                S_ABORT: begin
                    abort_entry <= 1'b0;
                    if (!bus.job_busy_i) begin
                        rr_ptr      <= owner_next;
                        owner_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    owner_valid <= 1'b0;
                    abort_entry <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o         = (state == S_GRANT) ? owner_bit : '0;
    assign bus.job_start_o   = (state == S_START);
    assign bus.abort_o       = (state == S_ABORT);
    assign bus.evt_done_o    = (state == S_DONE) ? owner_bit : '0;
    assign bus.evt_err_o     = ((state == S_ABORT) && abort_entry) ? owner_bit : '0;
    assign bus.busy_o        = (state != S_IDLE);
    assign bus.owner_o       = owner;
    assign bus.owner_valid_o = owner_valid;
    assign bus.jobs_cnt_o    = jobs_cnt;
endmodule

// File: tb/tb_multi_dataflow_job_arbiter.sv
// Randomized bench for the job arbiter: a transaction-level model tracks the round-robin pointer
// and job counter, and each job's grant/start/done/abort timeline is checked cycle by cycle.
module tb_multi_dataflow_job_arbiter;
    localparam int N_REQ     = 4;
    localparam int TIMEOUT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_bad    = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;

    multi_dataflow_job_arbiter_if #(.N_REQ(N_REQ), .TIMEOUT_W(TIMEOUT_W)) bus ();

    multi_dataflow_job_arbiter #(.N_REQ(N_REQ), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester at or after ptr, wrapping around.
    function automatic int rr_pick(input logic [N_REQ-1:0] pat, input int ptr);
        for (int i = 0; i < N_REQ; i++) begin
            if (pat[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return 0;
    endfunction

    task automatic check_quiet(input string tag);
        check_output({tag, "_gnt"},   32'(bus.gnt_o), 32'd0);
        check_output({tag, "_start"}, 32'(bus.job_start_o), 32'd0);
        check_output({tag, "_abort"}, 32'(bus.abort_o), 32'd0);
        check_output({tag, "_evt"},   32'({bus.evt_done_o, bus.evt_err_o}), 32'd0);
        check_output({tag, "_busy"},  32'({bus.busy_o, bus.owner_valid_o}), 32'd0);
        check_output({tag, "_cnt"},   32'(bus.jobs_cnt_o), 32'(m_cnt));
    endtask

    task automatic do_clear();
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        check_quiet("clr");
        check_output("clr_owner", 32'(bus.owner_o), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.job_done_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_quiet("idle");
        end
        bus.job_done_i = 1'b0;
    endtask

    // Called at a falling edge while the arbiter is idle; returns at a falling edge in idle.
    task automatic apply_stimulus(input logic [N_REQ-1:0] pat, input int done_at, input int tmo,
                                  input int busy_cycles, input bit keep_req, input int clear_at);
        int own;
        logic [N_REQ-1:0] own_bit;
        int k;
        int outcome;
        int n_abort;
        own     = rr_pick(pat, m_ptr);
        own_bit = N_REQ'(1) << own;
        bus.req_i      = pat;
        bus.timeout_i  = TIMEOUT_W'(tmo);
        bus.job_busy_i = 1'b0;
        @(negedge clk);
        check_output("gnt",        32'(bus.gnt_o), 32'(own_bit));
        check_output("owner",      32'(bus.owner_o), 32'(own));
        check_output("owner_vld",  32'(bus.owner_valid_o), 32'd1);
        check_output("gnt_nostart", 32'(bus.job_start_o), 32'd0);
        check_output("gnt_busy",   32'(bus.busy_o), 32'd1);
        if (!keep_req) bus.req_i = '0;
        @(negedge clk);
        check_output("start",      32'(bus.job_start_o), 32'd1);
        check_output("start_nognt", 32'(bus.gnt_o), 32'd0);
        bus.job_busy_i = 1'b1;
        k = 0;
        outcome = 0;
        while (outcome == 0) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_output("run_quiet", 32'({bus.abort_o, bus.job_start_o, bus.evt_done_o, bus.evt_err_o}), 32'd0);
            end
            if (clear_at == k) begin
                bus.clear_i = 1'b1;
                outcome = 3;
            end else if (done_at == k) begin
                bus.job_done_i = 1'b1;
                outcome = 1;
            end else if (tmo != 0 && k == tmo) begin
                outcome = 2;
            end
        end
        check_output("run_busy", 32'({bus.busy_o, bus.abort_o}), 32'h2);
        @(negedge clk);
        bus.job_done_i = 1'b0;
        bus.clear_i    = 1'b0;
        bus.req_i      = '0;
        if (outcome == 1) begin
            check_output("evt_done",   32'(bus.evt_done_o), 32'(own_bit));
            check_output("done_noerr", 32'({bus.evt_err_o, bus.abort_o}), 32'd0);
            bus.job_busy_i = 1'b0;
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_ptr = (own + 1) % N_REQ;
            @(negedge clk);
            check_quiet("after_done");
            check_output("owner_hold", 32'(bus.owner_o), 32'(own));
        end else if (outcome == 2) begin
            check_output("evt_err",     32'(bus.evt_err_o), 32'(own_bit));
            check_output("err_nodone",  32'(bus.evt_done_o), 32'd0);
            n_abort = 0;
            while (bus.abort_o === 1'b1 && n_abort < 20) begin
                n_abort++;
                if (n_abort > 1) check_output("err_once", 32'(bus.evt_err_o), 32'd0);
                bus.job_busy_i = (n_abort <= busy_cycles);
                @(negedge clk);
            end
            check_output("abort_len", 32'(n_abort), 32'(busy_cycles + 1));
            bus.job_busy_i = 1'b0;
            m_ptr = (own + 1) % N_REQ;
            check_quiet("after_abort");
        end else begin
            bus.job_busy_i = 1'b0;
            m_ptr = 0;
            m_cnt = 0;
            check_quiet("after_clear");
            check_output("clear_owner", 32'(bus.owner_o), 32'd0);
        end
    endtask

    initial begin
        int pat;
        int tmo;
        int done_at;
        int term;
        int clear_at;
        bit bad_seen;
        bus.clear_i    = 1'b0;
        bus.req_i      = '0;
        bus.job_busy_i = 1'b0;
        bus.job_done_i = 1'b0;
        bus.timeout_i  = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check_output("reset_owner", 32'(bus.owner_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");

        $display("[TB] single request, done after 10 run cycles");
        apply_stimulus(4'b0100, 10, 0, 0, 1'b0, 0);
        check_output("t1_cnt", 32'(bus.jobs_cnt_o), 32'd1);

        $display("[TB] all requesters held, round-robin order");
        do_clear();
        for (int j = 0; j < 5; j++) apply_stimulus(4'b1111, 3, 0, 0, 1'b1, 0);
        check_output("t2_cnt", 32'(bus.jobs_cnt_o), 32'd5);

        $display("[TB] watchdog expiry and same-cycle done");
        apply_stimulus(4'b1111, 0, 8, 4, 1'b0, 0);
        check_output("t3_cnt", 32'(bus.jobs_cnt_o), 32'd5);
        apply_stimulus(4'b1111, 8, 8, 0, 1'b0, 0);
        check_output("t4_cnt", 32'(bus.jobs_cnt_o), 32'd6);

        $display("[TB] clear mid-run");
        do_clear();
        apply_stimulus(4'b0100, 0, 0, 0, 1'b0, 3);
        apply_stimulus(4'b1100, 2, 0, 0, 1'b0, 0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 200; j++) begin
            pat     = $urandom_range(1, 15);
            tmo     = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            done_at = $urandom_range(0, 12);
            if (tmo == 0 && done_at == 0) done_at = $urandom_range(1, 12);
            if (done_at == 0) term = tmo;
            else if (tmo == 0) term = done_at;
            else term = (done_at < tmo) ? done_at : tmo;
            clear_at = ($urandom_range(0, 19) == 0) ? $urandom_range(1, term) : 0;
            apply_stimulus(N_REQ'(pat), done_at, tmo, $urandom_range(0, 4), 1'($urandom_range(0, 1)), clear_at);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        $display("[TB] disabled watchdog, long job");
        bus.req_i     = 4'b0001;
        bus.timeout_i = '0;
        @(negedge clk);
        check_output("long_gnt", 32'(bus.gnt_o), 32'(N_REQ'(1) << rr_pick(4'b0001, m_ptr)));
        bus.req_i = '0;
        @(negedge clk);
        check_output("long_start", 32'(bus.job_start_o), 32'd1);
        bus.job_busy_i = 1'b1;
        bad_seen = 1'b0;
        for (int k = 1; k <= 70000; k++) begin
            @(negedge clk);
            if (bus.abort_o || bus.evt_err_o != '0 || bus.evt_done_o != '0 || !bus.busy_o) bad_seen = 1'b1;
            // A wrapped watchdog would equal 69999 mod 65536 here; a saturated one never matches.
            bus.timeout_i = (k == 70000) ? TIMEOUT_W'(4464) : '0;
        end
        @(negedge clk);
        bus.timeout_i = '0;
        check_output("long_noerr", 32'({bad_seen, bus.abort_o, bus.evt_err_o}), 32'd0);
        check_output("long_busy", 32'(bus.busy_o), 32'd1);
        bus.job_done_i = 1'b1;
        @(negedge clk);
        bus.job_done_i = 1'b0;
        bus.job_busy_i = 1'b0;
        check_output("long_done", 32'(bus.evt_done_o), 32'(N_REQ'(1) << m_ptr));
        m_cnt = m_cnt + 1;
        m_ptr = (m_ptr + 1) % N_REQ;
        @(negedge clk);
        check_quiet("long_after");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
